// File: rtl/aes_cmd_issue.sv
// AES command front-end: buffers opcode+tag commands in a small FIFO, issues them one at a
// time to the round controller and returns a tagged completion record with error status.
package aes_pkg;
    typedef enum logic [1:0] {
        NOOP            = 2'd0,
        AESENC          = 2'd1,
        AESENCLAST      = 2'd2,
        AESKEYGENASSIST = 2'd3
    } opcode;
endpackage

module aes_cmd_issue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  aes_pkg::opcode         cmd_op_i,
    input  logic [TAG_W-1:0]       cmd_tag_i,
    output logic                   start_o,
    output aes_pkg::opcode         opcode_o,
    input  logic                   cipher_ready_i,
    input  logic                   key_ready_i,
    output logic                   done_valid_o,
    input  logic                   done_ready_i,
    output logic [TAG_W-1:0]       done_tag_o,
    output aes_pkg::opcode         done_op_o,
    output logic                   done_err_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] level_o
);
    import aes_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);
    localparam logic [TW-1:0] TMAX     = '1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

    state_t           state;
    opcode            fifo_op  [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    opcode            cur_op;
    logic [TAG_W-1:0] cur_tag;
    logic [TW-1:0]    timer;
    logic             expect_key, good_done;

    // Handshakes: a command transfers on any cycle with cmd_valid_i && cmd_ready_o; a completion
    // record transfers on any cycle with done_valid_o && done_ready_i. Neither side may retract.
    assign cmd_ready_o = (count != FULL_LVL);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign level_o     = count;
    assign busy_o      = (state != S_IDLE) || (count != '0);

    // Only the expected completion alone counts as success; a wrong or doubled strobe is an error.
    assign expect_key  = (cur_op == AESKEYGENASSIST);
    assign good_done   = expect_key ? (key_ready_i && !cipher_ready_i)
                                    : (cipher_ready_i && !key_ready_i);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= cmd_op_i;
            fifo_tag[wr_ptr] <= cmd_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            cur_op       <= NOOP;
            cur_tag      <= '0;
            start_o      <= 1'b0;
            opcode_o     <= NOOP;
            done_valid_o <= 1'b0;
            done_tag_o   <= '0;
            done_op_o    <= NOOP;
            done_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_op  <= fifo_op[rd_ptr];
                        cur_tag <= fifo_tag[rd_ptr];
                        if (fifo_op[rd_ptr] == NOOP) begin
                            // NOOP never reaches the controller; it retires immediately without error.
                            state        <= S_RETIRE;
                            done_valid_o <= 1'b1;
                            done_tag_o   <= fifo_tag[rd_ptr];
                            done_op_o    <= NOOP;
                            done_err_o   <= 1'b0;
                        end else begin
                            state    <= S_ISSUE;
                            start_o  <= 1'b1;
                            opcode_o <= fifo_op[rd_ptr];
                        end
                    end
                end
                S_ISSUE: begin
                    start_o  <= 1'b0;
                    opcode_o <= NOOP;
                    timer    <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Retire when the timer is about to reach TIMEOUT-1, so the error record appears
                    // TIMEOUT cycles after the start pulse.
                    if (cipher_ready_i || key_ready_i || (timer == TO_LAST)) begin
                        state        <= S_RETIRE;
                        done_valid_o <= 1'b1;
                        done_tag_o   <= cur_tag;
                        done_op_o    <= cur_op;
                        done_err_o   <= !good_done;
                    end
                    if (timer != TMAX) timer <= timer + 1'b1;
                end
                S_RETIRE: begin
                    if (done_ready_i) begin
                        done_valid_o <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
